// File: rtl/dtw_path_reader.sv
// dtw_path_reader
// Reads the path words that the backtrace stage left in the DTW result SRAM,
// starting at a base address and moving to increasing addresses. Each word is
// decoded into a (test index, reference index) point and sent on a valid/ready
// stream. The DTW score comes from the first word only.
//
// Ports:
//   clk, nrst       clock and synchronous active-low reset
//   i_start         job start pulse, honoured only when idle
//   i_base_addr     address of the first path word, sampled with i_start
//   o_busy, o_done  job in progress / one-cycle end-of-job pulse
//   o_err           sticky error (pad bits set or count limit hit), cleared on start
//   o_sram_cen      SRAM read enable (one cycle per word)
//   o_sram_addr     SRAM read address
//   i_sram_rdata    SRAM read data, valid one cycle after o_sram_cen
//   o_valid         point valid
//   i_ready         point accepted when high with o_valid
//   o_tidx, o_ridx  decoded point
//   o_last          final point of the path
//   o_score         DTW distance from the first word
module dtw_path_reader #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned MAX_LEN = 63
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_sram_cen,
    output logic [ADDR_W-1:0] o_sram_addr,
    input  logic [31:0]       i_sram_rdata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [4:0]        o_tidx,
    output logic [4:0]        o_ridx,
    output logic              o_last,
    output logic [15:0]       o_score
);

    localparam int unsigned CntW = $clog2(MAX_LEN);
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StCap,
        StSend,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [4:0]        tidx_q, tidx_d;
    logic [4:0]        ridx_q, ridx_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [15:0]       score_q, score_d;

    logic [4:0] rd_tidx;
    logic [4:0] rd_ridx;
    logic       pad_bad;
    logic       at_origin;
    logic       at_limit;

    assign rd_tidx   = i_sram_rdata[28:24];
    assign rd_ridx   = i_sram_rdata[20:16];
    assign pad_bad   = (|i_sram_rdata[31:29]) | (|i_sram_rdata[23:21]);
    assign at_origin = (rd_tidx == 5'd0) && (rd_ridx == 5'd0);
    assign at_limit  = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tidx_d  = tidx_q;
        ridx_d  = ridx_q;
        last_d  = last_q;
        err_d   = err_q;
        score_d = score_q;

        o_busy      = (state_q != StIdle);
        o_done      = (state_q == StDone);
        o_sram_cen  = (state_q == StReq);
        o_valid     = (state_q == StSend);
        o_last      = (state_q == StSend) && last_q;
        o_sram_addr = addr_q;
        o_tidx      = tidx_q;
        o_ridx      = ridx_q;
        o_err       = err_q;
        o_score     = score_q;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    addr_d  = i_base_addr;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StCap;
            end
            StCap: begin
                tidx_d = rd_tidx;
                ridx_d = rd_ridx;
                if (cnt_q == '0) begin
                    score_d = i_sram_rdata[15:0];
                end
                last_d = at_origin || at_limit;
                // Running out of words before reaching (0,0) means a broken path.
                if (pad_bad || (at_limit && !at_origin)) begin
                    err_d = 1'b1;
                end
                state_d = StSend;
            end
            StSend: begin
                if (i_ready) begin
                    if (last_q) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        cnt_d   = cnt_q + CntW'(1);
                        state_d = StReq;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            tidx_q  <= '0;
            ridx_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tidx_q  <= tidx_d;
            ridx_q  <= ridx_d;
            last_q  <= last_d;
            err_q   <= err_d;
            score_q <= score_d;
        end
    end

endmodule

// File: tb/tb_dtw_path_reader.sv
// Testbench for dtw_path_reader: SRAM model, scoreboard of expected points.
module tb_dtw_path_reader;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [5:0]  base_addr;
    logic        busy, done, err;
    logic        sram_cen;
    logic [5:0]  sram_addr;
    logic [31:0] sram_rdata = '0;
    logic        valid, ready, last;
    logic [4:0]  tidx, ridx;
    logic [15:0] score;

    logic [31:0] mem [64];
    logic [5:0]  rd_q [$];
    logic [10:0] exp_q [$];

    int checks   = 0;
    int failures = 0;

    dtw_path_reader #(
        .ADDR_W (6),
        .MAX_LEN(63)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_start     (start),
        .i_base_addr (base_addr),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_sram_cen  (sram_cen),
        .o_sram_addr (sram_addr),
        .i_sram_rdata(sram_rdata),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_tidx      (tidx),
        .o_ridx      (ridx),
        .o_last      (last),
        .o_score     (score)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM; every read address is logged in issue order.
    always @(posedge clk) begin
        if (sram_cen) begin
            sram_rdata <= mem[sram_addr];
            rd_q.push_back(sram_addr);
        end
    end

    function automatic logic [31:0] w(input logic [4:0] t, input logic [4:0] r,
                                      input logic [15:0] s);
        return {3'b000, t, 3'b000, r, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [4:0] t, input logic [4:0] r, input logic l);
        exp_q.push_back({t, r, l});
    endtask

    task automatic load_diag();
        mem[0] = w(5'd2, 5'd2, 16'h01A4);
        mem[1] = w(5'd1, 5'd1, 16'h7777);
        mem[2] = w(5'd0, 5'd0, 16'h5555);
        push(5'd2, 5'd2, 1'b0);
        push(5'd1, 5'd1, 1'b0);
        push(5'd0, 5'd0, 1'b1);
    endtask

    task automatic run_job(input logic [5:0] base, input bit toggle, input bit mid_start,
                           input logic [15:0] exp_score, input logic exp_err,
                           input int exp_reads);
        int          cyc, first_v, hs_last, done_cyc, rd0;
        bit          stalled;
        logic [10:0] held, e;
        logic [5:0]  a;
        rd0 = rd_q.size();
        @(negedge clk);
        base_addr = base;
        start     = 1'b1;
        cyc = 0; first_v = -1; hs_last = -1; done_cyc = -1; stalled = 1'b0; held = '0;
        while (done_cyc < 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start     = mid_start && (cyc == 10);
            base_addr = mid_start ? 6'd33 : base;
            ready     = toggle ? cyc[0] : 1'b1;
            if (cyc == 1) begin
                chk("busy_after_start", busy, 1);
                chk("err_cleared_on_start", err, 0);
            end
            if (valid && first_v < 0) first_v = cyc;
            if (stalled && valid) chk("stall_hold", {tidx, ridx, last}, held);
            stalled = valid && !ready;
            held    = {tidx, ridx, last};
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_point", {tidx, ridx, last}, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("point", {tidx, ridx, last}, e);
                end
                if (last) hs_last = cyc;
            end
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        ready = 1'b1;
        chk("done_seen", (done_cyc >= 0), 1);
        chk("first_valid_latency", first_v, 3);
        chk("done_after_last_hs", done_cyc - hs_last, 1);
        chk("points_left", exp_q.size(), 0);
        chk("score", score, exp_score);
        chk("err", err, exp_err);
        chk("read_count", rd_q.size() - rd0, exp_reads);
        for (int i = 0; i < exp_reads && rd0 + i < rd_q.size(); i++) begin
            a = base + 6'(i);
            chk("read_addr", rd_q[rd0 + i], a);
        end
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_single_pulse", done, 0);
        chk("err_hold", err, exp_err);
        chk("score_hold", score, exp_score);
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {busy, done, err, sram_cen, valid, last}, 0);
        chk(tag, {sram_addr, tidx, ridx}, 0);
        chk(tag, score, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        nrst = 1'b0; start = 1'b0; base_addr = '0; ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        nrst = 1'b1;

        // Diagonal path, ready held high.
        load_diag();
        run_job(6'd0, 1'b0, 1'b0, 16'h01A4, 1'b0, 3);

        // Same job with ready toggling.
        load_diag();
        run_job(6'd0, 1'b1, 1'b0, 16'h01A4, 1'b0, 3);

        // Address wrap from 62.
        mem[62] = w(5'd3, 5'd1, 16'h0BCD);
        mem[63] = w(5'd2, 5'd1, 16'h0000);
        mem[0]  = w(5'd1, 5'd0, 16'h0000);
        mem[1]  = w(5'd0, 5'd0, 16'h0000);
        push(5'd3, 5'd1, 1'b0); push(5'd2, 5'd1, 1'b0);
        push(5'd1, 5'd0, 1'b0); push(5'd0, 5'd0, 1'b1);
        run_job(6'd62, 1'b0, 1'b0, 16'h0BCD, 1'b0, 4);

        // Pad bit set in the third word.
        mem[10] = w(5'd2, 5'd1, 16'h0042);
        mem[11] = w(5'd1, 5'd1, 16'h0000);
        mem[12] = w(5'd1, 5'd0, 16'h0000) | 32'h2000_0000;
        mem[13] = w(5'd0, 5'd0, 16'h0000);
        push(5'd2, 5'd1, 1'b0); push(5'd1, 5'd1, 1'b0);
        push(5'd1, 5'd0, 1'b0); push(5'd0, 5'd0, 1'b1);
        run_job(6'd10, 1'b0, 1'b0, 16'h0042, 1'b1, 4);

        // Clean job afterwards clears the error.
        load_diag();
        run_job(6'd0, 1'b0, 1'b0, 16'h01A4, 1'b0, 3);

        // 63 words without reaching (0,0); start pulse mid-job must be ignored.
        for (int i = 0; i < 63; i++) begin
            mem[i] = w(5'((i % 31) + 1), 5'd7, 16'hBEEF + 16'(i));
            push(5'((i % 31) + 1), 5'd7, (i == 62));
        end
        run_job(6'd0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 63);

        // Reset while a point is stalled in SEND.
        load_diag();
        @(negedge clk);
        base_addr = 6'd0; start = 1'b1; ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!valid && n < 20);
        chk("reached_send", valid, 1);
        nrst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset_mid_job");
        nrst  = 1'b1;
        ready = 1'b1;
        exp_q.delete();
        load_diag();
        run_job(6'd0, 1'b0, 1'b0, 16'h01A4, 1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dtw_path_reader.md
# dtw_path_reader

Readback engine for the DTW result SRAM. It fetches the path words written by the backtrace stage and decodes each one into a (test index, reference index) point. Points go out on a valid/ready stream, and the final DTW score is latched from the first word. It sits between the result SRAM read port and the host/output interface, mirroring the backtrace writer on the same memory format.

## Interface
- ADDR_W, 6, SRAM word-address width
- MAX_LEN, 63, maximum path words read per job (2·32−1)
- clk  in  1  clock, all logic on rising edge
- nrst  in  1  synchronous active-low reset
- i_start  in  1  job start pulse, accepted only in IDLE
- i_base_addr  in  ADDR_W  address of first path word (sampled with i_start)
- o_busy  out  1  high from cycle after accepted start until DONE exits
- o_done  out  1  one-cycle pulse at job end
- o_err  out  1  sticky error flag, cleared on accepted start
- o_sram_cen  out  1  read enable, active high
- o_sram_addr  out  ADDR_W  read address
- i_sram_rdata  in  32  read data, valid exactly 1 cycle after o_sram_cen
- o_valid  out  1  path point valid
- i_ready  in  1  downstream accepts point
- o_tidx  out  5  test-sequence index
- o_ridx  out  5  reference-sequence index
- o_last  out  1  current point is final point of path
- o_score  out  16  DTW distance latched from first word

## Operation
- Word format: [31:29]=0, [28:24]=tidx, [23:21]=0, [20:16]=ridx, [15:0]=score. Score is meaningful in the first word only; it is ignored in later words.
- Words are stored in backtrace order: the first word is the end cell (T−1,R−1) and the path ends at (0,0). The reader emits points in increasing address order.
- FSM states: IDLE, REQ, CAP, SEND, DONE.
  - IDLE: when i_start=1, load addr←i_base_addr, cnt←0, clear o_err, go to REQ.
  - REQ: drive o_sram_cen=1 and o_sram_addr=addr, go to CAP.
  - CAP: register tidx/ridx from i_sram_rdata.
    - If cnt=0, set o_score←rdata[15:0].
    - If rdata[31:29]≠0 or rdata[23:21]≠0, set o_err.
    - Compute last = (tidx=0 && ridx=0) || (cnt=MAX_LEN−1). If last is due only to the count limit, set o_err.
    - Go to SEND.
  - SEND: o_valid=1 with outputs held stable. When i_ready=1 and last, go to DONE. When i_ready=1 and not last, addr←addr+1 (wraps modulo 2^ADDR_W), cnt←cnt+1, go to REQ.
  - DONE: o_done=1, go to IDLE.
- i_start is ignored outside IDLE.
- A pad-bit error does not stop the job; the point is still delivered.

## Timing
- Reset (nrst=0 at an edge): state IDLE. o_busy, o_done, o_err, o_sram_cen, o_valid and o_last are 0; o_sram_addr, o_tidx, o_ridx and o_score are 0. Reset mid-job aborts immediately; no o_done.
- Start accepted at edge k: REQ in cycle k+1, CAP in k+2, o_valid=1 from k+3.
- With i_ready held high, throughput is one point per 3 cycles.
- o_sram_cen is high only in REQ, for 1 cycle per word. No read is issued while SEND stalls.
- When o_valid=1 and i_ready=0, o_tidx, o_ridx and o_last stay stable until handshake.
- o_done rises the cycle after the final handshake. o_busy falls together with o_done's deassertion, i.e. it is low from the cycle after DONE.
- o_score and o_err hold their values from job end until the next accepted start.
- The earliest next start is accepted in the cycle after DONE.

## Test plan
- Diagonal path, base=0, words (2,2,score=0x01A4),(1,1),(0,0), i_ready=1. Expect:
  - points (2,2),(1,1),(0,0)
  - o_last on the 3rd point only
  - o_score=0x01A4, o_err=0
  - first o_valid 3 cycles after start, o_done 1 cycle after 3rd handshake.
- Same job with i_ready toggling 0/1 every cycle → identical point sequence, outputs stable while stalled, exactly 3 o_sram_cen pulses.
- base=62 (ADDR_W=6), 4-word path → read addresses 62,63,0,1 in order.
- Corrupt pad bit (word 0x2000_0000 | valid fields) in word 2 → o_err=1, all points still delivered, o_err stays 1 after o_done, cleared by next start.
- No (0,0) in 63 words → 63 points, o_last on point 63, o_err=1; i_start pulsed mid-job is ignored.
- nrst=0 asserted during SEND → next cycle all outputs 0, IDLE; a new start then produces a normal job.
